muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller for RV32M ops flagged by the ALU control unit (funct7=1 selection codes).
//  Sits beside the EX-stage ALU: accepts op + operands, runs a 1-cycle multiply or a radix-2
//  iterative divide, and holds the pipeline via stall until the result is ready. Base ALU ops never enter it.
// PARAMETERS
//  XLEN       32             operand/result width
//  CNT_W      $clog2(XLEN)+1 divide iteration counter width (derived, not overridden)
// PORTS
//  clk      in   1     rising-edge clock; the only clock
//  rst_n    in   1     asynchronous, active-low reset
//  start    in   1     EX stage holds an M-ext op; held high by pipeline while stall=1
//  flush    in   1     EX flush (branch/exception); aborts in-flight op
//  alu_sel  in   5     ALU selection: 00010 MUL,00011 MULH,00110 MULHSU,01011 MULHU,
//                      01100 DIV,10000 DIVU,10001 REM,10010 REMU
//  op_a     in   XLEN  rs1 value (dividend / multiplicand)
//  op_b     in   XLEN  rs2 value (divisor / multiplier)
//  result   out  XLEN  final result; valid only while done=1
//  done     out  1     1-cycle pulse, result valid
//  busy     out  1     state != IDLE
//  stall    out  1     freeze IF/ID/EX: (IDLE & start & valid sel) | (state not IDLE/DONE)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, result=0, done=0, busy=0, stall=0, counter/regs=0; takes effect mid-op.
//  - start with alu_sel not in the 8 codes above: ignored, stall=0. start outside IDLE: ignored.
//  - FSM: IDLE -> MUL | DIV | DONE; MUL -> DONE; DIV -> FIX after XLEN iterations; FIX -> DONE; DONE -> IDLE.
//  - Operands and alu_sel latched at the accepting edge; later input changes have no effect.
//  - MUL family: 2*XLEN product of sign/zero-extended operands (MULHSU: a signed, b unsigned);
//    MUL = low half, others = high half. Edge0 accept, edge1 compute, done high in cycle after edge1 (latency 2).
//  - DIV family: restoring radix-2 on magnitudes, one quotient bit per cycle, XLEN cycles; FIX applies signs
//    (quotient negative iff signs differ, remainder takes dividend sign). done at cycle XLEN+2 after accept.
//  - Special cases decided at accept, straight to DONE (latency 1): divisor=0 -> quotient all-ones,
//    remainder=op_a; signed overflow (op_a=0x80000000, op_b=-1) -> quotient 0x80000000, remainder 0.
//  - DONE: stall=0 so EX advances at that edge; start seen in DONE is not re-accepted.
//  - flush: any state -> IDLE at next edge, no done pulse, result unchanged; flush wins over start.
//  - result holds last value outside done; consumers must qualify with done.
// CONFIGURATION
//  - MULDIV_RESULT_CACHE_EN defined: last completed divide keeps {op_a, op_b, signedness, quotient, remainder};
//    a new DIV/DIVU/REM/REMU with identical operands and signedness goes IDLE->DONE (latency 1) returning
//    the cached quotient or remainder. Cache invalidated by reset and by flush of a divide in flight.
//  - Undefined: no cache storage; every divide takes the full XLEN+2 path.
// STRUCTURE
//  - package muldiv_pkg: 5-bit selection-code localparams (shared with ALU control unit), FSM state
//    encoding (IDLE, MUL, DIV, FIX, DONE), helper is_div/is_signed decode constants.
//  - Sub-module div_radix2_core: remainder/quotient shift registers + one compare-subtract step per cycle,
//    driven by load/step enables from this FSM. Multiply stays inline.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, done 2 cycles after start, stall high 2 cycles.
//  2. op_a=op_b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF.
//  3. DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; done at cycle 34, stall high cycles 0..33.
//  4. DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; all latency 1.
//  5. flush at DIV cycle 10 -> no done, IDLE next cycle, following MUL 6*7=42 correct;
//     rst_n low at DIV cycle 20 -> stall/busy/done/result 0 immediately.
//  6. DIV 100/7 then REM 100/7: result 14 then 2; REM done at cycle 1 with MULDIV_RESULT_CACHE_EN, cycle 34 without.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared RV32M selection codes, FSM encoding and decode helpers
// for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [4:0] SEL_MUL    = 5'b00010;
    localparam logic [4:0] SEL_MULH   = 5'b00011;
    localparam logic [4:0] SEL_MULHSU = 5'b00110;
    localparam logic [4:0] SEL_MULHU  = 5'b01011;
    localparam logic [4:0] SEL_DIV    = 5'b01100;
    localparam logic [4:0] SEL_DIVU   = 5'b10000;
    localparam logic [4:0] SEL_REM    = 5'b10001;
    localparam logic [4:0] SEL_REMU   = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic is_mul(input logic [4:0] s);
        return (s == SEL_MUL) || (s == SEL_MULH) ||
               (s == SEL_MULHSU) || (s == SEL_MULHU);
    endfunction

    function automatic logic is_div(input logic [4:0] s);
        return (s == SEL_DIV) || (s == SEL_DIVU) ||
               (s == SEL_REM) || (s == SEL_REMU);
    endfunction

    function automatic logic is_valid_sel(input logic [4:0] s);
        return is_mul(s) || is_div(s);
    endfunction

    function automatic logic is_signed_div(input logic [4:0] s);
        return (s == SEL_DIV) || (s == SEL_REM);
    endfunction

    function automatic logic is_rem(input logic [4:0] s);
        return (s == SEL_REM) || (s == SEL_REMU);
    endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Restoring radix-2 divider datapath on unsigned magnitudes:
// one quotient bit per step, sequenced by the muldiv FSM.
module div_radix2_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            // Borrow out of the trial subtract means the bit is 0: restore.
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: 1-cycle multiply, radix-2 divide.
// Optional last-divide result cache: MULDIV_RESULT_CACHE_EN.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [4:0]        sel_q, sel_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic              accept;
    logic              in_sgn;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic              div_load, div_step;
    logic [XLEN-1:0]   core_quo, core_rem;
    logic [XLEN-1:0]   fix_quo, fix_rem;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_res;

    logic              ma_sgn, mb_sgn;
    logic [2*XLEN-1:0] ma, mb, prod;

    assign accept = (state_q == S_IDLE) && start &&
                    is_valid_sel(alu_sel) && !flush;

    assign in_sgn   = is_signed_div(alu_sel);
    assign a_neg    = in_sgn & op_a[XLEN-1];
    assign b_neg    = in_sgn & op_b[XLEN-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = in_sgn && (op_a == MIN_NEG) && (op_b == '1);

    // Full-width product of the extended operands; low 2*XLEN bits suffice.
    assign ma_sgn = (sel_q == SEL_MULH) || (sel_q == SEL_MULHSU);
    assign mb_sgn = (sel_q == SEL_MULH);
    assign ma     = {{XLEN{ma_sgn & a_q[XLEN-1]}}, a_q};
    assign mb     = {{XLEN{mb_sgn & b_q[XLEN-1]}}, b_q};
    assign prod   = ma * mb;

    assign fix_quo = qneg_q ? -core_quo : core_quo;
    assign fix_rem = rneg_q ? -core_rem : core_rem;

    div_radix2_core #(
        .XLEN (XLEN)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

`ifdef MULDIV_RESULT_CACHE_EN
    logic            cv_q, cv_d;
    logic            cs_q, cs_d;
    logic [XLEN-1:0] ca_q, ca_d;
    logic [XLEN-1:0] cb_q, cb_d;
    logic [XLEN-1:0] cquo_q, cquo_d;
    logic [XLEN-1:0] crem_q, crem_d;

    assign cache_hit = cv_q && (ca_q == op_a) &&
                       (cb_q == op_b) && (cs_q == in_sgn);
    assign cache_res = is_rem(alu_sel) ? crem_q : cquo_q;

    always_comb begin
        cv_d   = cv_q;
        cs_d   = cs_q;
        ca_d   = ca_q;
        cb_d   = cb_q;
        cquo_d = cquo_q;
        crem_d = crem_q;
        if (flush) begin
            if ((state_q == S_DIV) || (state_q == S_FIX)) begin
                cv_d = 1'b0;
            end
        end else if (state_q == S_FIX) begin
            cv_d   = 1'b1;
            cs_d   = is_signed_div(sel_q);
            ca_d   = a_q;
            cb_d   = b_q;
            cquo_d = fix_quo;
            crem_d = fix_rem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q   <= 1'b0;
            cs_q   <= 1'b0;
            ca_q   <= '0;
            cb_q   <= '0;
            cquo_q <= '0;
            crem_q <= '0;
        end else begin
            cv_q   <= cv_d;
            cs_q   <= cs_d;
            ca_q   <= ca_d;
            cb_q   <= cb_d;
            cquo_q <= cquo_d;
            crem_q <= crem_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sel_d = alu_sel;
                    a_d   = op_a;
                    b_d   = op_b;
                    if (is_mul(alu_sel)) begin
                        state_d = S_MUL;
                    end else if (div_zero) begin
                        result_d = is_rem(alu_sel) ? op_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = is_rem(alu_sel) ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else if (cache_hit) begin
                        result_d = cache_res;
                        state_d  = S_DONE;
                    end else begin
                        div_load = 1'b1;
                        cnt_d    = '0;
                        qneg_d   = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        state_d  = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = (sel_q == SEL_MUL) ? prod[XLEN-1:0]
                                              : prod[2*XLEN-1:XLEN];
                state_d  = S_DONE;
            end
            S_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = is_rem(sel_q) ? fix_rem : fix_quo;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort leaves the last delivered result visible.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            div_load = 1'b0;
            div_step = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    assign stall  = rst_n &&
                    (((state_q == S_IDLE) && start && is_valid_sel(alu_sel)) ||
                     ((state_q != S_IDLE) && (state_q != S_DONE)));

endmodule
